// File: rtl/prng_symbol_packer_if.sv
// Bundles the configuration, serial-bit and symbol-handshake signals of the
// PRNG symbol packer so the driver and the packer share one port.
interface prng_symbol_packer_if #(
  parameter int MAXSYMBOLWIDTH = 128,
  parameter int MW             = $clog2(MAXSYMBOLWIDTH) + 1
);
  logic                      load_mode;
  logic [MW-1:0]             mode;
  logic                      bit_valid;
  logic                      bit_in;
  logic                      sym_valid;
  logic                      sym_ready;
  logic [MAXSYMBOLWIDTH-1:0] sym_data;
  logic [MW-1:0]             sym_width;
  logic                      mode_err;
  logic                      overflow;
  logic [15:0]               drop_count;

  modport master (
    output load_mode, mode, bit_valid, bit_in, sym_ready,
    input  sym_valid, sym_data, sym_width, mode_err, overflow, drop_count
  );

  modport slave (
    input  load_mode, mode, bit_valid, bit_in, sym_ready,
    output sym_valid, sym_data, sym_width, mode_err, overflow, drop_count
  );
endinterface

// File: rtl/prng_symbol_packer.sv
// Packs a serial PRNG bit stream into symbols of a run-time selectable width
// and offers each completed symbol through a single-entry valid/ready holding register.
module prng_symbol_packer #(
  parameter int MAXSYMBOLWIDTH = 128,
  parameter int MW             = $clog2(MAXSYMBOLWIDTH) + 1
) (
  input  logic                clock,
  input  logic                reset,
  prng_symbol_packer_if.slave bus
);

  localparam int IDX_W = (MAXSYMBOLWIDTH > 1) ? $clog2(MAXSYMBOLWIDTH) : 1;

  // ACCUM is split into an empty and a full holding-register flavour.
  typedef enum logic [1:0] {
    S_UNCONFIGURED = 2'd0,
    S_ACCUM_EMPTY  = 2'd1,
    S_ACCUM_FULL   = 2'd2
  } state_e;

  state_e                    state_q,     state_d;
  logic [MW-1:0]             mode_r_q,    mode_r_d;
  logic [IDX_W-1:0]          bit_idx_q,   bit_idx_d;
  logic [MAXSYMBOLWIDTH-1:0] shift_q,     shift_d;
  logic [MAXSYMBOLWIDTH-1:0] hold_q,      hold_d;
  logic [MW-1:0]             width_q,     width_d;
  logic                      sym_valid_q, sym_valid_d;
  logic                      mode_err_q,  mode_err_d;
  logic                      overflow_q,  overflow_d;
  logic [15:0]               drop_q,      drop_d;

  logic [MAXSYMBOLWIDTH-1:0] shift_new;
  logic                      last_bit;
  logic                      accept_bit;
  logic                      transfer;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic mode_legal(input logic [MW-1:0] m);
    return (m != '0) && (m <= MW'(MAXSYMBOLWIDTH));
  endfunction

  always_comb begin
    state_d    = state_q;
    mode_r_d   = mode_r_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    hold_d     = hold_q;
    width_d    = width_q;
    overflow_d = overflow_q;
    drop_d     = drop_q;
    mode_err_d = 1'b0;

    transfer   = (state_q == S_ACCUM_FULL) && bus.sym_ready;
    accept_bit = (state_q != S_UNCONFIGURED) && bus.bit_valid && !bus.load_mode;

    shift_new            = shift_q;
    shift_new[bit_idx_q] = bus.bit_in;
    last_bit             = (MW'(bit_idx_q) == (mode_r_q - MW'(1)));

    if (transfer) begin
      state_d = S_ACCUM_EMPTY;
    end

    // A mode load wins over a bit arriving in the same cycle; that bit is lost.
    if (bus.load_mode) begin
      if (mode_legal(bus.mode)) begin
        mode_r_d  = bus.mode;
        bit_idx_d = '0;
        shift_d   = '0;
        if (state_q == S_UNCONFIGURED) begin
          state_d = S_ACCUM_EMPTY;
        end
      end else begin
        mode_err_d = 1'b1;
      end
    end else if (accept_bit) begin
      if (last_bit) begin
        bit_idx_d = '0;
        shift_d   = '0;
        if ((state_q == S_ACCUM_EMPTY) || transfer) begin
          hold_d  = shift_new;
          width_d = mode_r_q;
          state_d = S_ACCUM_FULL;
        end else begin
          overflow_d = 1'b1;
          drop_d     = sat_inc16(drop_q);
        end
      end else begin
        shift_d   = shift_new;
        bit_idx_d = bit_idx_q + IDX_W'(1);
      end
    end

    sym_valid_d = (state_d == S_ACCUM_FULL);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_UNCONFIGURED;
      mode_r_q    <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      width_q     <= '0;
      sym_valid_q <= 1'b0;
      mode_err_q  <= 1'b0;
      overflow_q  <= 1'b0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      mode_r_q    <= mode_r_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      width_q     <= width_d;
      sym_valid_q <= sym_valid_d;
      mode_err_q  <= mode_err_d;
      overflow_q  <= overflow_d;
      drop_q      <= drop_d;
    end
  end

  assign bus.sym_valid  = sym_valid_q;
  assign bus.sym_data   = hold_q;
  assign bus.sym_width  = width_q;
  assign bus.mode_err   = mode_err_q;
  assign bus.overflow   = overflow_q;
  assign bus.drop_count = drop_q;

endmodule

// File: tb/tb_prng_symbol_packer.sv
// Directed bench for prng_symbol_packer: a queue-based symbol model checked every
// cycle, plus literal expectations for the reference scenarios.
module tb_prng_symbol_packer;

  logic clock;
  logic reset;

  prng_symbol_packer_if bus ();

  prng_symbol_packer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_pass  = 0;
  int n_total = 0;

  // Model state: configuration, bits of the partial symbol, and the offered symbol.
  bit           started = 0;
  bit           m_cfg   = 0;
  int           m_mode  = 0;
  bit           m_bits[$];
  bit           m_full  = 0;
  logic [127:0] m_data  = '0;
  int           m_width = 0;
  bit           m_err   = 0;
  bit           m_ovf   = 0;
  int           m_drop  = 0;
  bit           xfer;
  bit           loaded;
  int           md_i;
  logic [127:0] sym;
  bit           saw_valid;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic step(input int lm, input int md, input int bv, input int bi, input int rdy);
    bus.load_mode = (lm != 0);
    bus.mode      = 8'(md);
    bus.bit_valid = (bv != 0);
    bus.bit_in    = (bi != 0);
    bus.sym_ready = (rdy != 0);
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(0, 0, 0, 0, 0);
    reset = 1'b0;
  endtask

  initial forever begin
    @(posedge clock);
    started = 1;
    if (reset) begin
      m_cfg = 0; m_mode = 0; m_bits.delete(); m_full = 0; m_data = '0;
      m_width = 0; m_err = 0; m_ovf = 0; m_drop = 0;
    end else begin
      xfer   = m_full && bus.sym_ready;
      loaded = 0;
      m_err  = 0;
      md_i   = int'(bus.mode);
      if (bus.load_mode) begin
        if (md_i >= 1 && md_i <= 128) begin
          m_mode = md_i;
          m_bits.delete();
          m_cfg  = 1;
        end else begin
          m_err = 1;
        end
      end else if (m_cfg && bus.bit_valid) begin
        m_bits.push_back(bus.bit_in);
        if (m_bits.size() == m_mode) begin
          sym = '0;
          foreach (m_bits[k]) if (m_bits[k]) sym = sym | (128'(1) << k);
          m_bits.delete();
          if (!m_full || bus.sym_ready) begin
            m_data = sym; m_width = m_mode; m_full = 1; loaded = 1;
          end else begin
            m_ovf = 1;
            if (m_drop < 65535) m_drop++;
          end
        end
      end
      if (xfer && !loaded) m_full = 0;
    end
  end

  initial forever begin
    @(negedge clock);
    if (started) begin
      check("cmp_sym_valid",  128'(bus.sym_valid),  128'(m_full));
      check("cmp_mode_err",   128'(bus.mode_err),   128'(m_err));
      check("cmp_overflow",   128'(bus.overflow),   128'(m_ovf));
      check("cmp_drop_count", 128'(bus.drop_count), 128'(m_drop));
      if (m_full) begin
        check("cmp_sym_data",  bus.sym_data,        m_data);
        check("cmp_sym_width", 128'(bus.sym_width), 128'(m_width));
      end
    end
  end

  initial begin
    reset = 1'b1;
    bus.load_mode = 1'b0; bus.mode = '0; bus.bit_valid = 1'b0;
    bus.bit_in = 1'b0; bus.sym_ready = 1'b0;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("rst_sym_valid",  128'(bus.sym_valid),  128'(0));
    check("rst_sym_data",   bus.sym_data,         128'(0));
    check("rst_sym_width",  128'(bus.sym_width),  128'(0));
    check("rst_mode_err",   128'(bus.mode_err),   128'(0));
    check("rst_overflow",   128'(bus.overflow),   128'(0));
    check("rst_drop_count", 128'(bus.drop_count), 128'(0));
    reset = 1'b0;

    // mode 4, bits 1,0,1,1 -> 0xD one cycle after the last bit, for one cycle
    step(1, 4, 0, 0, 1);
    step(0, 0, 1, 1, 1);
    step(0, 0, 1, 0, 1);
    step(0, 0, 1, 1, 1);
    check("m4_not_early", 128'(bus.sym_valid), 128'(0));
    step(0, 0, 1, 1, 1);
    check("m4_valid", 128'(bus.sym_valid), 128'(1));
    check("m4_data",  bus.sym_data,        128'(13));
    check("m4_width", 128'(bus.sym_width), 128'(4));
    step(0, 0, 0, 0, 1);
    check("m4_one_cycle", 128'(bus.sym_valid), 128'(0));

    // illegal modes pulse mode_err and leave the packer unconfigured
    do_reset();
    step(1, 0, 0, 0, 1);
    check("err_mode0", 128'(bus.mode_err), 128'(1));
    step(1, 129, 0, 0, 1);
    check("err_mode129", 128'(bus.mode_err), 128'(1));
    step(0, 0, 0, 0, 1);
    check("err_pulse_end", 128'(bus.mode_err), 128'(0));
    saw_valid = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1, i % 2, 1);
      saw_valid = saw_valid | bus.sym_valid;
    end
    check("err_no_symbol", 128'(saw_valid), 128'(0));

    // mode 2, consumer stalled: first symbol held, next two dropped
    do_reset();
    step(1, 2, 0, 0, 0);
    step(0, 0, 1, 1, 0); step(0, 0, 1, 0, 0);
    step(0, 0, 1, 1, 0); step(0, 0, 1, 1, 0);
    step(0, 0, 1, 0, 0); step(0, 0, 1, 1, 0);
    check("drop_valid",    128'(bus.sym_valid),  128'(1));
    check("drop_data",     bus.sym_data,         128'(1));
    check("drop_width",    128'(bus.sym_width),  128'(2));
    check("drop_overflow", 128'(bus.overflow),   128'(1));
    check("drop_count",    128'(bus.drop_count), 128'(2));
    step(1, 3, 0, 0, 0);
    check("reload_keeps_valid", 128'(bus.sym_valid),  128'(1));
    check("reload_keeps_data",  bus.sym_data,         128'(1));
    check("reload_keeps_width", 128'(bus.sym_width),  128'(2));
    check("reload_keeps_ovf",   128'(bus.overflow),   128'(1));
    check("reload_keeps_drops", 128'(bus.drop_count), 128'(2));
    step(0, 0, 0, 0, 1);
    check("drain_valid", 128'(bus.sym_valid), 128'(0));

    // completion with full holding register and ready in the same cycle
    do_reset();
    step(1, 2, 0, 0, 0);
    step(0, 0, 1, 1, 0); step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0); step(0, 0, 1, 1, 1);
    check("repl_valid", 128'(bus.sym_valid),  128'(1));
    check("repl_data",  bus.sym_data,         128'(2));
    check("repl_drops", 128'(bus.drop_count), 128'(0));
    check("repl_ovf",   128'(bus.overflow),   128'(0));
    step(0, 0, 0, 0, 1);
    check("repl_drain", 128'(bus.sym_valid), 128'(0));

    // reload mid-symbol with a colliding bit that must be discarded
    do_reset();
    step(1, 8, 0, 0, 1);
    step(0, 0, 1, 1, 1); step(0, 0, 1, 0, 1); step(0, 0, 1, 1, 1);
    step(1, 3, 1, 0, 1);
    step(0, 0, 1, 1, 1); step(0, 0, 1, 1, 1);
    check("coll_not_early", 128'(bus.sym_valid), 128'(0));
    step(0, 0, 1, 1, 1);
    check("coll_valid", 128'(bus.sym_valid), 128'(1));
    check("coll_data",  bus.sym_data,        128'(7));
    check("coll_width", 128'(bus.sym_width), 128'(3));

    // one-bit symbols
    do_reset();
    step(1, 1, 0, 0, 1);
    step(0, 0, 1, 1, 1);
    check("m1_data_a", bus.sym_data,        128'(1));
    check("m1_width",  128'(bus.sym_width), 128'(1));
    step(0, 0, 1, 0, 1);
    check("m1_valid_b", 128'(bus.sym_valid), 128'(1));
    check("m1_data_b",  bus.sym_data,        128'(0));

    // full-width symbols with a reset in the middle of a partial symbol
    do_reset();
    step(1, 128, 0, 0, 1);
    for (int i = 0; i < 100; i++) step(0, 0, 1, (i % 3 == 0) ? 1 : 0, 1);
    reset = 1'b1;
    step(0, 0, 1, 1, 1);
    reset = 1'b0;
    check("midrst_valid", 128'(bus.sym_valid), 128'(0));
    check("midrst_data",  bus.sym_data,        128'(0));
    step(1, 128, 0, 0, 1);
    for (int i = 0; i < 127; i++) step(0, 0, 1, 1, 1);
    check("m128_not_early", 128'(bus.sym_valid), 128'(0));
    step(0, 0, 1, 1, 1);
    check("m128_valid", 128'(bus.sym_valid), 128'(1));
    check("m128_data",  bus.sym_data,        {128{1'b1}});
    check("m128_width", 128'(bus.sym_width), 128'(128));
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/prng_symbol_packer.md
PRNG_SYMBOL_PACKER -- requirements
Module: prng_symbol_packer

Interface
REQ-001 Parameter MAXSYMBOLWIDTH, default 128: maximum symbol width in bits.
REQ-002 Parameter MW, default $clog2(MAXSYMBOLWIDTH)+1: width of the mode and count fields.
REQ-003 clock  input  1  single clock; all logic SHALL be on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 load_mode  input  1  one-cycle strobe that captures mode.
REQ-006 mode  input  MW  symbol width in bits; legal range 1..MAXSYMBOLWIDTH.
REQ-007 bit_valid  input  1  bit_in is valid this cycle; driven by the upstream LFSR valid.
REQ-008 bit_in  input  1  serial PRNG bit from the upstream LFSR.
REQ-009 sym_valid  output  1  sym_data holds a complete symbol.
REQ-010 sym_ready  input  1  consumer accepts the symbol when sym_valid and sym_ready are both high.
REQ-011 sym_data  output  MAXSYMBOLWIDTH  packed symbol, first received bit at bit 0; bits at index mode_r and above SHALL be 0.
REQ-012 sym_width  output  MW  value of mode_r at the time the held symbol was completed.
REQ-013 mode_err  output  1  one-cycle pulse when load_mode presents an illegal mode.
REQ-014 overflow  output  1  sticky; set when a completed symbol is dropped.
REQ-015 drop_count  output  16  number of dropped symbols; saturates at 0xFFFF.

Function
REQ-016 FSM states SHALL be UNCONFIGURED, ACCUM and, within ACCUM, the holding register is either empty or full.
REQ-017 UNCONFIGURED: bit_valid SHALL be ignored; a legal load_mode SHALL move the FSM to ACCUM.
REQ-018 Legal load_mode: mode_r SHALL be set to mode, bit_idx cleared to 0, the shift register cleared, and any partial symbol discarded.
REQ-019 Illegal load_mode (mode 0 or mode > MAXSYMBOLWIDTH): mode_r, the FSM state and bit_idx SHALL stay unchanged, and mode_err SHALL pulse on the next cycle.
REQ-020 ACCUM with bit_valid=1: bit_in SHALL be written to shift[bit_idx], and bit_idx SHALL increment.
REQ-021 Symbol completion: when bit_idx == mode_r-1 and bit_valid=1, the completed symbol is the shift register with the new bit included; bit_idx SHALL wrap to 0 and the shift register SHALL clear.
REQ-022 Latency: when the final bit is accepted in cycle N, sym_valid SHALL be high in cycle N+1.
REQ-023 Handshake: while sym_valid=1 and sym_ready=0, sym_data and sym_width SHALL be held stable.
REQ-024 Handshake: sym_valid SHALL deassert the cycle after a transfer unless a new symbol is loaded in the same cycle.
REQ-025 Completion with the holding register empty: the symbol SHALL be loaded into the holding register.
REQ-026 Completion while the holding register is full and sym_ready=1 in the same cycle: the new symbol SHALL replace the held one, sym_valid SHALL stay 1, and there SHALL be no drop.
REQ-027 Completion while the holding register is full and sym_ready=0: the new symbol SHALL be discarded, overflow SHALL be set, drop_count SHALL increment (saturating), and the held symbol SHALL be unchanged.
REQ-028 load_mode and bit_valid in the same cycle: load_mode SHALL take priority and that bit SHALL be discarded.
REQ-029 load_mode while the holding register is full: the held symbol, sym_valid and sym_width SHALL be retained until transferred.
REQ-030 mode_r = 1: every valid bit SHALL complete a one-bit symbol.
REQ-031 mode_r = MAXSYMBOLWIDTH: all bits of sym_data SHALL be used.
REQ-032 overflow and drop_count SHALL clear only on reset; load_mode SHALL not clear them.

Reset
REQ-033 While reset=1, the FSM SHALL be UNCONFIGURED, and mode_r, bit_idx, the shift register, the holding register and drop_count SHALL be 0.
REQ-034 While reset=1, sym_valid, sym_data, sym_width, mode_err and overflow SHALL be 0.
REQ-035 Reset asserted mid-symbol or mid-handshake SHALL discard all state by the next edge; load_mode is required again after reset.

Verification
REQ-036 mode=4 loaded, bits 1,0,1,1 on consecutive cycles, sym_ready=1 -> sym_data=0x0000_000D, sym_width=4, sym_valid high for exactly 1 cycle, one cycle after the 4th bit.
REQ-037 mode=0 and then mode=129 presented on load_mode -> mode_err pulses twice; FSM stays UNCONFIGURED; 8 subsequent valid bits produce no sym_valid.
REQ-038 mode=2, sym_ready=0, 6 valid bits -> first symbol held; 2nd and 3rd symbols dropped; overflow=1; drop_count=2.
REQ-039 mode=2, sym_ready=1 asserted in the same cycle as the 4th bit with the holding register full -> 2nd symbol replaces the 1st; drop_count=0.
REQ-040 mode=8 loaded, 3 bits accepted, then load_mode with mode=3 and bit_valid=1 in the same cycle, then bits 1,1,1 -> sym_data=0x7, sym_width=3.
REQ-041 mode=128, 100 bits accepted, then reset for 1 cycle, then mode=128 reloaded and 128 bits of 1 -> sym_data all ones, with no stale bits from before the reset.
